ws2811_serial_receiver: RTL
===========================

Name: ws2811_serial_receiver

Overview:
- Decodes a WS2811 one-wire NRZ pulse stream back into 24-bit pixel words. It is the receive end of the protocol that WS2811_array_controller transmits.
- Used for on-chip loopback checking of the LED driver's `db_serial` output, and for capturing frames from an external LED strip master.
- Latches up to MAX_LEDS pixels per frame and reports frame completion and protocol errors.

Parameters:
- BIT_THRESH, 30: high-pulse length in clocks at or above which a bit decodes as 1 (0.6 us at 50 MHz).
- MIN_HIGH, 8: high pulses shorter than this are glitches and raise an error.
- MAX_HIGH, 60: a high level lasting this many clocks is a stuck-high error.
- RESET_LOW, 2500: low time in clocks that marks a frame latch gap (50 us).
- MAX_LEDS, 5: number of pixel registers kept.

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-low reset (0 = reset)
- serial_in  in  1  WS2811 data line, asynchronous to clock
- clear_err  in  1  one-cycle pulse; clears err_flags
- pixel  out  24  last decoded pixel, bit 23 = first bit received
- pixel_valid  out  1  one-cycle strobe when pixel updates
- pixel_idx  out  8  index of pixel within frame (0-based), saturates at 255
- led0..led4  out  24 each  pixels 0..4 of the current frame
- led_count  out  8  pixels received in last completed frame, saturates at 255
- frame_done  out  1  one-cycle strobe at end of a frame
- err_flags  out  3  sticky: [0] glitch, [1] stuck-high, [2] truncated word
- db_state  out  3  current FSM state encoding

Behaviour:
- Reset: all outputs 0; FSM in SYNC; counters 0.
- serial_in passes through a 2-flop synchronizer; all edges are detected on the synchronized signal.
- Counters:
  - high_cnt and low_cnt are 12-bit and saturate; they never wrap.
  - bit_cnt is 5-bit (0..23).
  - pix_cnt is 8-bit and saturates at 255.
- FSM:
  - SYNC: counts low time; any high level zeroes the count. Reaching RESET_LOW -> ARMED, with no frame_done. This prevents decoding a stream joined mid-frame.
  - ARMED: rising edge -> HIGH, with high_cnt=1, bit_cnt=0, pix_cnt=0.
  - HIGH: high_cnt++ each cycle.
    - Falling edge with high_cnt < MIN_HIGH: set err[0], go to SYNC.
    - Valid falling edge: shift in (high_cnt >= BIT_THRESH), then bit_cnt++ and go to LOW.
    - high_cnt reaches MAX_HIGH: set err[1], go to SYNC.
  - LOW: low_cnt++ each cycle; rising edge -> HIGH.
    - low_cnt reaches RESET_LOW with bit_cnt==0: pulse frame_done, led_count<=pix_cnt, go to ARMED.
    - low_cnt reaches RESET_LOW with bit_cnt!=0: set err[2], discard the partial word, pulse frame_done, led_count<=pix_cnt, go to ARMED.
- Word completion: on the 24th valid falling edge, in the cycle after that edge is seen:
  - pixel<=shift word and pixel_valid=1;
  - pixel_idx<=pix_cnt;
  - if pix_cnt < MAX_LEDS, ledN (N=pix_cnt) <= word;
  - then pix_cnt++ and bit_cnt<=0.
- Pixels beyond MAX_LEDS still strobe pixel_valid but update no ledN.
- ledN registers keep their previous-frame values until overwritten.
- Latency: pixel_valid asserts 3 clocks after the falling edge of the 24th bit on the pin (2 synchronizer + 1 register).
- Simultaneous clear_err and a new error in the same cycle: the new error wins and its flag is set.
- Reset asserted mid-frame: immediate return to reset values. The block must see a full RESET_LOW gap before decoding again.

Optional Feature:
- Macro: WS2811_RX_GLITCH_FILTER_EN.
- Defined: a 3-sample majority filter follows the synchronizer. Single-cycle spikes are suppressed, and latency grows by 2 clocks (5 total).
- Undefined: the synchronizer output feeds edge detection directly.

Decomposition:
- Shared package holds:
  - state encodings SYNC=0, ARMED=1, HIGH=2, LOW=3, matching db_state;
  - err_flags bit positions;
  - default timing constants for a 50 MHz clock.
- One sub-module, ws2811_pulse_meter:
  - contains the synchronizer, the optional filter, edge detection and the saturating high/low counters;
  - outputs rise, fall, high_cnt and low_cnt.
- The top level keeps the FSM, the shift register and the pixel registers.

Test Plan:
- Idle low for 2500 clocks, then 5 pixels 0xFF0000, 0x00FF00, 0x0000FF, 0x123456, 0xABCDEF (bit 0 = 20-clock high / 42 low, bit 1 = 40 high / 22 low), then 2500 low -> 5 pixel_valid strobes with idx 0..4, led0..led4 equal to those values, led_count=5, frame_done once, err_flags=0.
- Loopback from WS2811_array_controller with led0..4 = 0xA5A5A5, 0x5A5A5A, 0xFFFFFF, 0x000000, 0x0F0F0F -> the same values are decoded.
- Same stream but no initial 2500-clock gap (start mid-pixel) -> no pixel_valid until the first full gap; the next frame decodes correctly.
- A 4-clock high spike mid-word -> err_flags=3'b001, FSM in SYNC. Then clear_err -> err_flags=0.
- Line held high 100 clocks -> err_flags[1]=1. Separately, 12 bits followed by 2500 low -> err_flags[2]=1, frame_done pulses, led_count=0.
- 7 pixels in one frame -> 7 pixel_valid strobes (idx 0..6), led_count=7, led0..4 hold pixels 0..4. With WS2811_RX_GLITCH_FILTER_EN, 1-clock spikes injected on the line cause no error.

Source files
------------

// File: rtl/ws2811_serial_receiver_pkg.sv
// ---------------------------------------------------------------------------
// ws2811_serial_receiver_pkg
//   Shared definitions for the WS2811 serial receiver:
//   - FSM state encodings (the values appear directly on db_state)
//   - err_flags bit positions
//   - default timing constants for a 50 MHz clock
//   - saturating increment helpers for the pulse and pixel counters
// ---------------------------------------------------------------------------
package ws2811_serial_receiver_pkg;

    typedef enum logic [2:0] {
        ST_SYNC  = 3'd0,   // waiting for a full latch gap before decoding
        ST_ARMED = 3'd1,   // gap seen, waiting for the first rising edge
        ST_HIGH  = 3'd2,   // measuring a high pulse
        ST_LOW   = 3'd3    // measuring the low time after a bit
    } rx_state_e;

    // err_flags bit positions
    localparam int ERR_GLITCH = 0;
    localparam int ERR_STUCK  = 1;
    localparam int ERR_TRUNC  = 2;
    localparam int ERR_W      = 3;

    // Widths
    localparam int CNT_W  = 12;
    localparam int WORD_W = 24;
    localparam int LED_PORTS = 5;

    // Default timing at 50 MHz
    localparam int DEF_BIT_THRESH = 30;    // 0.6 us
    localparam int DEF_MIN_HIGH   = 8;
    localparam int DEF_MAX_HIGH   = 60;
    localparam int DEF_RESET_LOW  = 2500;  // 50 us
    localparam int DEF_MAX_LEDS   = 5;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ws2811_serial_receiver_pulse_meter.sv
// ---------------------------------------------------------------------------
// ws2811_pulse_meter
//   Front end of the WS2811 receiver. Brings the asynchronous data line into
//   the clock domain, optionally cleans it, detects edges and measures how
//   long the line has been high or low.
//
//   Optional feature (macro WS2811_RX_GLITCH_FILTER_EN): a 3-sample majority
//   filter after the synchronizer removes single-cycle spikes and adds two
//   clocks of latency.
//
//   Ports:
//     clock     in   system clock
//     reset     in   asynchronous active-low reset
//     serial_in in   raw WS2811 data line (asynchronous)
//     rise      out  synchronized line went 0 -> 1 this cycle
//     fall      out  synchronized line went 1 -> 0 this cycle
//     high_cnt  out  consecutive high samples before this cycle (saturating)
//     low_cnt   out  consecutive low samples before this cycle (saturating)
// ---------------------------------------------------------------------------
module ws2811_pulse_meter
    import ws2811_serial_receiver_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             serial_in,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt
);

    logic sync1;
    logic sync2;
    logic line;
    logic line_prev;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= serial_in;
            sync2 <= sync1;
        end
    end

`ifdef WS2811_RX_GLITCH_FILTER_EN
    // Majority of the newest three synchronized samples, registered. A
    // transition needs two agreeing samples, so a 1-cycle spike never wins.
    logic hist1;
    logic hist2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist1 <= 1'b0;
            hist2 <= 1'b0;
            line  <= 1'b0;
        end else begin
            hist1 <= sync2;
            hist2 <= hist1;
            line  <= (sync2 & hist1) | (sync2 & hist2) | (hist1 & hist2);
        end
    end
`else
    assign line = sync2;
`endif

    // A count reflects the samples before the current cycle, so on the
    // falling-edge cycle high_cnt equals the full width of the high pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            line_prev <= 1'b0;
            high_cnt  <= '0;
            low_cnt   <= '0;
        end else begin
            line_prev <= line;
            high_cnt  <= line ? sat_inc_cnt(high_cnt) : '0;
            low_cnt   <= line ? '0 : sat_inc_cnt(low_cnt);
        end
    end

    assign rise = line & ~line_prev;
    assign fall = ~line & line_prev;

endmodule

// File: rtl/ws2811_serial_receiver.sv
// ---------------------------------------------------------------------------
// ws2811_serial_receiver
//   Decodes a WS2811 NRZ pulse stream into 24-bit pixel words, stores the
//   first MAX_LEDS pixels of each frame and reports frame completion and
//   protocol errors.
//
//   Optional feature: WS2811_RX_GLITCH_FILTER_EN (see ws2811_pulse_meter).
//
//   Ports:
//     clock        in   system clock (50 MHz)
//     reset        in   asynchronous active-low reset
//     serial_in    in   WS2811 data line, asynchronous to clock
//     clear_err    in   one-cycle pulse, clears err_flags
//     pixel        out  last decoded pixel, bit 23 = first bit received
//     pixel_valid  out  one-cycle strobe when pixel updates
//     pixel_idx    out  index of pixel within frame, saturates at 255
//     led0..led4   out  pixels 0..4 of the current frame
//     led_count    out  pixels in the last completed frame, saturates at 255
//     frame_done   out  one-cycle strobe at end of a frame
//     err_flags    out  sticky [0] glitch, [1] stuck-high, [2] truncated word
//     db_state     out  current FSM state (rx_state_e encoding)
//
//   Strobe semantics: pixel_valid and frame_done are single-cycle pulses with
//   no ready/backpressure; pixel/pixel_idx are stable from the pixel_valid
//   cycle until the next pixel_valid, and led_count likewise after
//   frame_done. The consumer must sample on the strobe cycle.
// ---------------------------------------------------------------------------
module ws2811_serial_receiver
    import ws2811_serial_receiver_pkg::*;
#(
    parameter int BIT_THRESH = DEF_BIT_THRESH,
    parameter int MIN_HIGH   = DEF_MIN_HIGH,
    parameter int MAX_HIGH   = DEF_MAX_HIGH,
    parameter int RESET_LOW  = DEF_RESET_LOW,
    parameter int MAX_LEDS   = DEF_MAX_LEDS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              serial_in,
    input  logic              clear_err,
    output logic [WORD_W-1:0] pixel,
    output logic              pixel_valid,
    output logic [7:0]        pixel_idx,
    output logic [WORD_W-1:0] led0,
    output logic [WORD_W-1:0] led1,
    output logic [WORD_W-1:0] led2,
    output logic [WORD_W-1:0] led3,
    output logic [WORD_W-1:0] led4,
    output logic [7:0]        led_count,
    output logic              frame_done,
    output logic [ERR_W-1:0]  err_flags,
    output logic [2:0]        db_state
);

    localparam logic [CNT_W-1:0] BIT_THRESH_C = CNT_W'(BIT_THRESH);
    localparam logic [CNT_W-1:0] MIN_HIGH_C   = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] MAX_HIGH_C   = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0] RESET_LOW_C  = CNT_W'(RESET_LOW);

    // -----------------------------------------------------------------
    // Pulse measurement front end
    // -----------------------------------------------------------------
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] low_cnt;

    ws2811_pulse_meter u_meter (
        .clock     (clock),
        .reset     (reset),
        .serial_in (serial_in),
        .rise      (rise),
        .fall      (fall),
        .high_cnt  (high_cnt),
        .low_cnt   (low_cnt)
    );

    logic gap_seen;
    logic stuck;
    logic glitch;
    logic bit_val;

    assign gap_seen = (low_cnt >= RESET_LOW_C);
    assign stuck    = (high_cnt >= MAX_HIGH_C);
    assign glitch   = (high_cnt < MIN_HIGH_C);
    assign bit_val  = (high_cnt >= BIT_THRESH_C);

    // -----------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------
    rx_state_e state_q;
    rx_state_e state_d;
    logic [4:0] bit_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------
    // A rise on the exact cycle a gap completes starts the new frame at
    // once instead of being lost in ARMED.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SYNC: begin
                if (gap_seen) state_d = rise ? ST_HIGH : ST_ARMED;
            end
            ST_ARMED: begin
                if (rise) state_d = ST_HIGH;
            end
            ST_HIGH: begin
                if (stuck) begin
                    state_d = ST_SYNC;
                end else if (fall) begin
                    state_d = glitch ? ST_SYNC : ST_LOW;
                end
            end
            ST_LOW: begin
                if (gap_seen) begin
                    state_d = rise ? ST_HIGH : ST_ARMED;
                end else if (rise) begin
                    state_d = ST_HIGH;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    // -----------------------------------------------------------------
    // FSM: outputs (control strobes for the datapath)
    // -----------------------------------------------------------------
    logic             start_frame;
    logic             shift_en;
    logic             frame_end;
    logic [ERR_W-1:0] err_set;

    always_comb begin
        start_frame = 1'b0;
        shift_en    = 1'b0;
        frame_end   = 1'b0;
        err_set     = '0;
        case (state_q)
            ST_SYNC: begin
                // SYNC -> ARMED never reports a frame
                start_frame = gap_seen & rise;
            end
            ST_ARMED: begin
                start_frame = rise;
            end
            ST_HIGH: begin
                if (stuck) begin
                    err_set[ERR_STUCK] = 1'b1;
                end else if (fall) begin
                    if (glitch) err_set[ERR_GLITCH] = 1'b1;
                    else        shift_en            = 1'b1;
                end
            end
            ST_LOW: begin
                if (gap_seen) begin
                    frame_end   = 1'b1;
                    start_frame = rise;
                    if (bit_cnt != 5'd0) err_set[ERR_TRUNC] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign db_state = state_q;

    // -----------------------------------------------------------------
    // Datapath: shift register, counters, pixel registers, flags
    // -----------------------------------------------------------------
    logic [WORD_W-2:0] shift_q;
    logic [WORD_W-1:0] word;
    logic [7:0]        pix_cnt;
    logic [WORD_W-1:0] led_q [LED_PORTS];

    // Previous 23 bits plus the bit being decoded this cycle
    assign word = {shift_q, bit_val};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_q     <= '0;
            bit_cnt     <= '0;
            pix_cnt     <= '0;
            pixel       <= '0;
            pixel_valid <= 1'b0;
            pixel_idx   <= '0;
            led_count   <= '0;
            frame_done  <= 1'b0;
            for (int i = 0; i < LED_PORTS; i++) led_q[i] <= '0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;

            // A truncated word is discarded simply by restarting bit_cnt
            if (frame_end) begin
                frame_done <= 1'b1;
                led_count  <= pix_cnt;
                bit_cnt    <= '0;
            end

            if (start_frame) begin
                bit_cnt <= '0;
                pix_cnt <= '0;
            end

            if (shift_en) begin
                shift_q <= word[WORD_W-2:0];
                if (bit_cnt == 5'd23) begin
                    pixel       <= word;
                    pixel_valid <= 1'b1;
                    pixel_idx   <= pix_cnt;
                    for (int i = 0; i < LED_PORTS; i++) begin
                        if (i < MAX_LEDS && pix_cnt == 8'(i)) led_q[i] <= word;
                    end
                    pix_cnt <= sat_inc8(pix_cnt);
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end
        end
    end

    // A new error in the same cycle as clear_err stays set
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_flags <= '0;
        end else begin
            err_flags <= (clear_err ? '0 : err_flags) | err_set;
        end
    end

    assign led0 = led_q[0];
    assign led1 = led_q[1];
    assign led2 = led_q[2];
    assign led3 = led_q[3];
    assign led4 = led_q[4];

endmodule
